// File: rtl/dram_ctrl_if.sv
// Host request/response bus and DRAM strobe bus for dram_ctrl.
// slave = controller side, master = host plus DRAM side.
interface dram_ctrl_if #(
  parameter int WordSize  = 16,
  parameter int AddrWidth = 16
);
  logic                 req;
  logic                 we;
  logic [AddrWidth-1:0] addr;
  logic [WordSize-1:0]  wdata;
  logic                 ready;
  logic                 ack;
  logic [WordSize-1:0]  rdata;
  logic                 mem_clk1;
  logic                 mem_clk2;
  logic [AddrWidth-1:0] mem_addr;
  logic [WordSize-1:0]  mem_din;
  logic                 mem_rd;
  logic                 mem_wr;
  logic [WordSize-1:0]  mem_dout;

  modport slave (
    input  req, we, addr, wdata, mem_dout,
    output ready, ack, rdata, mem_clk1, mem_clk2, mem_addr, mem_din, mem_rd, mem_wr
  );

  modport master (
    output req, we, addr, wdata, mem_dout,
    input  ready, ack, rdata, mem_clk1, mem_clk2, mem_addr, mem_din, mem_rd, mem_wr
  );
endinterface

// File: rtl/dram_ctrl.sv
// Front-end for a two-phase DRAM: one host request at a time, address on clk2, data on clk1.
// Optional DRAM_CTRL_IDLE_X_EN drives mem_addr/mem_din to X outside their legal windows.
module dram_ctrl #(
  parameter int WordSize  = 16,
  parameter int AddrWidth = 16
) (
  input  logic         clk,
  input  logic         rst,
  dram_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ADDR, DATA} state_t;

  state_t               r_state, w_next;
  logic [1:0]           r_ph;
  logic                 r_clk1, r_clk2;
  logic                 r_we;
  logic [AddrWidth-1:0] r_addr;
  logic [WordSize-1:0]  r_wdata;
  logic [AddrWidth-1:0] r_mem_addr;
  logic [WordSize-1:0]  r_mem_din;
  logic                 r_rd, r_wr;
  logic                 r_ack;
  logic [WordSize-1:0]  r_rdata;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_load_addr;
  logic                 w_load_data;
  logic                 w_done;
  logic [AddrWidth-1:0] w_addr_src;

  assign w_ready  = (r_state == IDLE);
  assign w_accept = bus.req && w_ready;
  // On a ph==0 accept the captured address is not yet registered, so take it from the bus.
  assign w_addr_src = (r_state == IDLE) ? bus.addr : r_addr;

  always_comb begin
    w_next      = r_state;
    w_load_addr = 1'b0;
    w_load_data = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        if (r_ph == 2'd0) begin
          w_next      = ADDR;
          w_load_addr = 1'b1;
        end else begin
          w_next = WAIT;
        end
      end
      WAIT: if (r_ph == 2'd0) begin
        w_next      = ADDR;
        w_load_addr = 1'b1;
      end
      ADDR: if (r_ph == 2'd2) begin
        w_next      = DATA;
        w_load_data = 1'b1;
      end
      DATA: if (r_ph == 2'd0) begin
        w_next = IDLE;
        w_done = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ph       <= 2'd3;
      r_clk1     <= 1'b0;
      r_clk2     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      r_ph    <= r_ph + 2'd1;
      // Strobes are registered from the phase about to be entered, so they are clean flops.
      r_clk1  <= (r_ph == 2'd3);
      r_clk2  <= (r_ph == 2'd1);
      r_ack   <= w_done;
      if (w_accept) begin
        r_we    <= bus.we;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (w_load_addr) r_mem_addr <= w_addr_src;
      if (w_load_data) begin
        r_mem_din <= r_wdata;
        r_rd      <= !r_we;
        r_wr      <= r_we;
      end
      if (w_done) begin
        r_rd <= 1'b0;
        r_wr <= 1'b0;
        if (!r_we) r_rdata <= bus.mem_dout;
      end
    end
  end

  assign bus.ready    = w_ready;
  assign bus.ack      = r_ack;
  assign bus.rdata    = r_rdata;
  assign bus.mem_clk1 = r_clk1;
  assign bus.mem_clk2 = r_clk2;
  assign bus.mem_rd   = r_rd;
  assign bus.mem_wr   = r_wr;

`ifdef DRAM_CTRL_IDLE_X_EN
  assign bus.mem_addr = (r_state == ADDR) ? r_mem_addr : {AddrWidth{1'bx}};
  assign bus.mem_din  = (r_state == DATA && r_we) ? r_mem_din : {WordSize{1'bx}};
`else
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_din  = r_mem_din;
`endif

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst) !(r_rd && r_wr));
  a_ack_ph1:    assert property (@(posedge clk) disable iff (rst) r_ack |-> (r_ph == 2'd1));
  a_strobe_dat: assert property (@(posedge clk) disable iff (rst) (r_rd || r_wr) |-> (r_state == DATA));

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl: cycle-window model of the transaction timeline plus a small DRAM.
module tb_dram_ctrl;
  localparam int WS = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_ctrl_if #(.WordSize(WS), .AddrWidth(AW)) bus ();
  dram_ctrl #(.WordSize(WS), .AddrWidth(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Two-phase DRAM: latches Addr on clk2 rise, moves data on clk1 rise.
  logic [WS-1:0] dmem [65536];
  logic [AW-1:0] d_lat = '0;
  logic [WS-1:0] d_out = '0;
  assign bus.mem_dout = d_out;
  always @(posedge bus.mem_clk2) d_lat <= bus.mem_addr;
  always @(posedge bus.mem_clk1) begin
    if (bus.mem_wr) dmem[d_lat] <= bus.mem_din;
    if (bus.mem_rd) d_out <= dmem[d_lat];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference phase and cycle index, derived only from clk and rst.
  logic [1:0] tb_ph = 2'd3;
  int cyc = 0;
  always @(posedge clk) begin
    tb_ph <= rst ? 2'd3 : tb_ph + 2'd1;
    cyc   <= cyc + 1;
  end

  // Model: a request seen in cycle c at phase p waits for the first ph==0 cycle z >= c;
  // address window z+1..z+2, data window z+3..z+4, ack in z+5, busy c+1..z+4.
  logic [WS-1:0] mm [65536];
  logic          mon_en = 1'b0;
  logic          busy = 1'b0;
  int            z = 0;
  logic          t_we = 1'b0;
  logic [AW-1:0] t_addr = '0;
  logic [WS-1:0] t_wdata = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [WS-1:0] exp_din = '0;
  logic [WS-1:0] exp_rdata = '0;
  logic          watch5 = 1'b0;
  logic          saw5 = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic e_ready, e_ack, e_rd, e_wr;
      if (busy) begin
        if (cyc == z + 1) exp_addr = t_addr;
        if (cyc == z + 3) exp_din = t_wdata;
        if (cyc == z + 4 && t_we) mm[t_addr] = t_wdata;
        if (cyc == z + 5 && !t_we) exp_rdata = mm[t_addr];
      end
      e_ready = !busy || (cyc > z + 4);
      e_ack   = busy && (cyc == z + 5);
      e_rd    = busy && !t_we && (cyc == z + 3 || cyc == z + 4);
      e_wr    = busy && t_we && (cyc == z + 3 || cyc == z + 4);
      chk("ready", bus.ready, e_ready);
      chk("ack", bus.ack, e_ack);
      chk("mem_rd", bus.mem_rd, e_rd);
      chk("mem_wr", bus.mem_wr, e_wr);
      chk("mem_clk1", bus.mem_clk1, tb_ph == 2'd0);
      chk("mem_clk2", bus.mem_clk2, tb_ph == 2'd2);
      chk("rdata", bus.rdata, exp_rdata);
`ifdef DRAM_CTRL_IDLE_X_EN
      if (busy && cyc >= z + 1 && cyc <= z + 2) chk("mem_addr", bus.mem_addr, exp_addr);
      if (busy && t_we && cyc >= z + 3 && cyc <= z + 4) chk("mem_din", bus.mem_din, exp_din);
`else
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_din", bus.mem_din, exp_din);
`endif
      if (watch5 && bus.mem_addr == 16'd5) saw5 = 1'b1;
      if (rst) begin
        busy = 1'b0; exp_addr = '0; exp_din = '0; exp_rdata = '0;
      end else begin
        if (busy && cyc >= z + 5) busy = 1'b0;
        if (e_ready && bus.req) begin
          busy    = 1'b1;
          z       = cyc + ((4 - int'(tb_ph)) % 4);
          t_we    = bus.we;
          t_addr  = bus.addr;
          t_wdata = bus.wdata;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ph(input logic [1:0] p);
    for (int i = 0; i < 8 && tb_ph != p; i++) tick();
  endtask

  // Issues one request and returns cycles from request cycle to ack cycle, plus what the
  // DRAM side showed during the clk2 and clk1 pulses.
  task automatic txn(input logic w, input logic [AW-1:0] a, input logic [WS-1:0] d,
                     output int lat, output logic [WS-1:0] rd,
                     output logic [AW-1:0] a_clk2, output logic rd_clk1, output logic wr_clk1);
    a_clk2 = '1; rd_clk1 = 1'b0; wr_clk1 = 1'b0;
    for (int i = 0; i < 20 && !bus.ready; i++) tick();
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    tick();
    bus.req = 1'b0;
    for (lat = 1; lat < 20 && !bus.ack; lat++) begin
      if (bus.mem_clk2) a_clk2 = bus.mem_addr;
      if (bus.mem_clk1) begin rd_clk1 = bus.mem_rd; wr_clk1 = bus.mem_wr; end
      tick();
    end
    chk("ack_seen", bus.ack, 1'b1);
    rd = bus.rdata;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2;
    logic [WS-1:0] rd, rd2;
    logic [AW-1:0] a2;
    logic r1, w1;
    int acks;
    for (int i = 0; i < 65536; i++) begin dmem[i] = '0; mm[i] = '0; end
    dmem[10] = 16'h1234; mm[10] = 16'h1234;
    dmem[1]  = 16'hBEEF; mm[1]  = 16'hBEEF;
    dmem[5]  = 16'h5555; mm[5]  = 16'h5555;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Reset for two edges, then watch clk1 cadence.
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_ack", bus.ack, 1'b0);
    chk("rst_rd_wr", {bus.mem_rd, bus.mem_wr}, 2'b00);
    chk("rst_clk1", bus.mem_clk1, 1'b0);
    rst = 1'b0;
    tick();
    chk("clk1_first", bus.mem_clk1, 1'b1);
    tick(); tick();
    chk("clk1_gap", bus.mem_clk1, 1'b0);
    chk("clk2_mid", bus.mem_clk2, 1'b1);
    tick(); tick();
    chk("clk1_period", bus.mem_clk1, 1'b1);

    // Read of preloaded address accepted at ph 1.
    wait_ph(2'd1);
    txn(1'b0, 16'd10, 16'h0, lat, rd, a2, r1, w1);
    chk("rd10_lat", lat, 8);
    chk("rd10_data", rd, 16'h1234);
    chk("rd10_addr_clk2", a2, 16'd10);
    chk("rd10_rd_clk1", {r1, w1}, 2'b10);

    // Write accepted at ph 0, then read it back.
    wait_ph(2'd0);
    txn(1'b1, 16'd2, 16'h06CF, lat, rd, a2, r1, w1);
    chk("wr2_lat", lat, 5);
    chk("wr2_wr_clk1", {r1, w1}, 2'b01);
    txn(1'b0, 16'd2, 16'h0, lat, rd, a2, r1, w1);
    chk("rd2_data", rd, 16'h06CF);

    // Back-to-back: second accept lands in the ack cycle (ph 1), so its ack comes 8 later.
    wait_ph(2'd2);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'd1;
    for (lat = 0; lat < 20 && !bus.ack; lat++) tick();
    chk("b2b_ack1", bus.ack, 1'b1);
    chk("b2b_ready_in_ack", bus.ready, 1'b1);
    rd = bus.rdata;
    bus.addr = 16'd10;
    tick();
    bus.req = 1'b0;
    for (lat2 = 1; lat2 < 20 && !bus.ack; lat2++) tick();
    rd2 = bus.rdata;
    chk("b2b_data1", rd, 16'hBEEF);
    chk("b2b_data2", rd2, 16'h1234);
    chk("b2b_spacing", lat2, 8);
    tick();

    // Request pulsed while busy must be dropped.
    watch5 = 1'b1; saw5 = 1'b0;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'd1;
    tick();
    bus.req = 1'b0;
    tick();
    bus.req = 1'b1; bus.addr = 16'd5;
    tick();
    bus.req = 1'b0;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ack) begin acks++; chk("busy_data", bus.rdata, 16'hBEEF); end
      tick();
    end
    chk("busy_acks", acks, 1);
    chk("busy_addr5", saw5, 1'b0);
    watch5 = 1'b0;

    // Reset in the first DATA cycle of a write, before the clk1 pulse.
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'd10; bus.wdata = 16'h7777;
    tick();
    bus.req = 1'b0;
    for (int i = 0; i < 12 && !bus.mem_wr; i++) tick();
    chk("rstmid_wr_seen", bus.mem_wr, 1'b1);
    rst = 1'b1;
    tick();
    chk("rstmid_wr", bus.mem_wr, 1'b0);
    chk("rstmid_ack", bus.ack, 1'b0);
    chk("rstmid_clk1", bus.mem_clk1, 1'b0);
    rst = 1'b0;
    chk("rstmid_ready", bus.ready, 1'b1);
    tick();
    chk("rstmid_ph0", bus.mem_clk1, 1'b1);
    txn(1'b0, 16'd10, 16'h0, lat, rd, a2, r1, w1);
    chk("rstmid_readback", rd, 16'h1234);

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
